// File: rtl/window_firing_fsm_param_if.sv
// Handshake and FIFO signals between the invoke module's level-1 FSM, the actor FIFOs
// and the window firing-state FSM.
interface window_firing_fsm_param_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LEN_W = 4
);
    logic             start_in;
    logic [1:0]       next_mode_in;
    logic [LEN_W-1:0] length_in;
    logic [1:0]       command_in;
    logic [WIDTH-1:0] data_in_fifo;
    logic             rd_in_data_fifo;
    logic             wr_out_fifo;
    logic [WIDTH-1:0] data_out;
    logic [1:0]       next_mode_out;
    logic             done_out;

    modport master (
        output start_in,
        output next_mode_in,
        output length_in,
        output command_in,
        output data_in_fifo,
        input  rd_in_data_fifo,
        input  wr_out_fifo,
        input  data_out,
        input  next_mode_out,
        input  done_out
    );

    modport slave (
        input  start_in,
        input  next_mode_in,
        input  length_in,
        input  command_in,
        input  data_in_fifo,
        output rd_in_data_fifo,
        output wr_out_fifo,
        output data_out,
        output next_mode_out,
        output done_out
    );
endinterface

// File: rtl/window_firing_fsm_param.sv
// Firing-state FSM of the window computation actor: one CFDF mode (setup/load, compute,
// output, clear) per start/done handshake, with local window memory and reduction datapath.
module window_firing_fsm_param #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LEN_W = 4
) (
    input logic                      clk,
    input logic                      rst,
    window_firing_fsm_param_if.slave bus_io
);

    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned SW = WIDTH + LEN_W;

    localparam logic [LEN_W-1:0] SizeLen = LEN_W'(SIZE);
    localparam logic [SW-1:0]    SatMax  = {{LEN_W{1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoadLast,
        StComp,
        StOutput,
        StClear,
        StEnd
    } state_e;

    typedef enum logic [1:0] {
        ModeSetup  = 2'b00,
        ModeComp   = 2'b01,
        ModeOutput = 2'b10,
        ModeClear  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CmdSum   = 2'b00,
        CmdMax   = 2'b01,
        CmdMin   = 2'b10,
        CmdRange = 2'b11
    } cmd_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       nm_q, nm_d;
    logic             wr_pend_q, wr_pend_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;

    logic [WIDTH-1:0] mem_q [SIZE];

    logic             cnt_last;
    logic             cnt_first;
    logic [WIDTH-1:0] elem;
    logic [SW-1:0]    sum_nxt;
    logic [WIDTH-1:0] max_nxt;
    logic [WIDTH-1:0] min_nxt;
    logic [WIDTH-1:0] sum_sat;
    logic [LEN_W-1:0] len_clamped;

    assign cnt_last  = (cnt_q == (len_q - LEN_W'(1)));
    assign cnt_first = (cnt_q == '0);
    assign elem      = mem_q[cnt_q[AW-1:0]];

    // Zero or oversized lengths fall back to the full window.
    assign len_clamped = ((bus_io.length_in == '0) || (bus_io.length_in > SizeLen)) ?
                         SizeLen : bus_io.length_in;

    // Accumulator step; the first element seeds all three accumulators.
    always_comb begin
        sum_nxt = cnt_first ? SW'(elem) : (sum_q + SW'(elem));
        max_nxt = (cnt_first || (elem > max_q)) ? elem : max_q;
        min_nxt = (cnt_first || (elem < min_q)) ? elem : min_q;
        sum_sat = (sum_nxt > SatMax) ? {WIDTH{1'b1}} : sum_nxt[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start_in) begin
                    unique case (mode_e'(bus_io.next_mode_in))
                        ModeSetup:  state_d = StLoad;
                        ModeComp:   state_d = StComp;
                        ModeOutput: state_d = StOutput;
                        ModeClear:  state_d = StClear;
                        default:    state_d = StIdle;
                    endcase
                end
            end
            StLoad: begin
                if (cnt_last) begin
                    state_d = StLoadLast;
                end
            end
            StLoadLast: state_d = StEnd;
            StComp: begin
                if (cnt_last) begin
                    state_d = StEnd;
                end
            end
            StOutput: state_d = StEnd;
            StClear:  state_d = StEnd;
            StEnd:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus_io.rd_in_data_fifo = 1'b0;
        bus_io.wr_out_fifo     = 1'b0;
        bus_io.done_out        = 1'b0;
        bus_io.next_mode_out   = 2'b00;
        bus_io.data_out        = result_q;
        unique case (state_q)
            StLoad:   bus_io.rd_in_data_fifo = 1'b1;
            StOutput: bus_io.wr_out_fifo     = 1'b1;
            StEnd: begin
                bus_io.done_out      = 1'b1;
                bus_io.next_mode_out = nm_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state: counters, latched configuration, accumulators, result.
    always_comb begin
        cnt_d     = cnt_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        sum_d     = sum_q;
        max_d     = max_q;
        min_d     = min_q;
        result_d  = result_q;
        nm_d      = nm_q;
        wr_pend_d = 1'b0;
        wr_idx_d  = wr_idx_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus_io.start_in && (mode_e'(bus_io.next_mode_in) == ModeSetup)) begin
                    len_d = len_clamped;
                    cmd_d = bus_io.command_in;
                end
            end
            StLoad: begin
                // Token for this read returns next cycle; remember where it goes.
                wr_pend_d = 1'b1;
                wr_idx_d  = cnt_q[AW-1:0];
                cnt_d     = cnt_q + LEN_W'(1);
            end
            StLoadLast: nm_d = ModeComp;
            StComp: begin
                sum_d = sum_nxt;
                max_d = max_nxt;
                min_d = min_nxt;
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_last) begin
                    nm_d = ModeOutput;
                    unique case (cmd_e'(cmd_q))
                        CmdSum:   result_d = sum_sat;
                        CmdMax:   result_d = max_nxt;
                        CmdMin:   result_d = min_nxt;
                        CmdRange: result_d = max_nxt - min_nxt;
                        default:  result_d = result_q;
                    endcase
                end
            end
            StOutput: nm_d = ModeSetup;
            StClear: begin
                result_d = '0;
                nm_d     = ModeSetup;
            end
            StEnd:   cnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            cmd_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            min_q     <= '0;
            result_q  <= '0;
            nm_q      <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            min_q     <= min_d;
            result_q  <= result_d;
            nm_q      <= nm_d;
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // Window memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            mem_q[wr_idx_q] <= bus_io.data_in_fifo;
        end
    end

endmodule

// File: tb/tb_window_firing_fsm_param.sv
// Directed bench for window_firing_fsm_param: one task per scenario with inline checks.
module tb_window_firing_fsm_param;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned WIDTH = 10;
    localparam int unsigned LEN_W = 4;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    logic [WIDTH-1:0] tok [16];
    int               ptr;

    int               done_cyc;
    int               rd_cnt;
    int               wr_cnt;
    logic [1:0]       nm;
    logic [WIDTH-1:0] wr_data;

    window_firing_fsm_param_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    window_firing_fsm_param #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One firing: start pulse, then observe outputs at each negedge until done_out.
    // The FIFO model presents tok[ptr] the cycle after each observed read.
    task automatic fire(input logic [1:0] mode, input logic [LEN_W-1:0] len,
                        input logic [1:0] cmd, input int poke_cyc);
        logic rd_seen;
        done_cyc = -1;
        rd_cnt   = 0;
        wr_cnt   = 0;
        nm       = 2'b00;
        wr_data  = '0;
        @(negedge clk);
        bus.start_in     = 1'b1;
        bus.next_mode_in = mode;
        bus.length_in    = len;
        bus.command_in   = cmd;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            rd_seen = bus.rd_in_data_fifo;
            if (rd_seen) rd_cnt++;
            if (bus.wr_out_fifo) begin
                wr_cnt++;
                wr_data = bus.data_out;
            end
            if (bus.done_out) begin
                done_cyc = k;
                nm       = bus.next_mode_out;
            end
            @(posedge clk);
            #1;
            if (rd_seen) begin
                bus.data_in_fifo = tok[ptr];
                ptr++;
            end
            bus.start_in = (k + 1 == poke_cyc);
            if (done_cyc >= 0) break;
        end
        bus.start_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.rd_in_data_fifo !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rd: got %0b want 0", bus.rd_in_data_fifo);
        end
        tests_run++;
        if (bus.wr_out_fifo !== 1'b0) begin
            tests_failed++; $display("FAIL reset_wr: got %0b want 0", bus.wr_out_fifo);
        end
        tests_run++;
        if (bus.done_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done: got %0b want 0", bus.done_out);
        end
        tests_run++;
        if (bus.data_out !== 10'd0) begin
            tests_failed++; $display("FAIL reset_data: got %0d want 0", bus.data_out);
        end
        tests_run++;
        if (bus.next_mode_out !== 2'b00) begin
            tests_failed++; $display("FAIL reset_nm: got %0b want 00", bus.next_mode_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_sum_basic();
        tok[0] = 10'd5; tok[1] = 10'd7; tok[2] = 10'd9; ptr = 0;
        fire(2'b00, 4'd3, 2'b00, 0);
        tests_run++;
        if (rd_cnt !== 3) begin
            tests_failed++; $display("FAIL sum_setup_rd: got %0d want 3", rd_cnt);
        end
        tests_run++;
        if (done_cyc !== 5) begin
            tests_failed++; $display("FAIL sum_setup_done: got %0d want 5", done_cyc);
        end
        tests_run++;
        if (nm !== 2'b01) begin
            tests_failed++; $display("FAIL sum_setup_nm: got %0b want 01", nm);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 4) begin
            tests_failed++; $display("FAIL sum_comp_done: got %0d want 4", done_cyc);
        end
        tests_run++;
        if (nm !== 2'b10) begin
            tests_failed++; $display("FAIL sum_comp_nm: got %0b want 10", nm);
        end
        fire(2'b10, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 2) begin
            tests_failed++; $display("FAIL sum_out_done: got %0d want 2", done_cyc);
        end
        tests_run++;
        if (nm !== 2'b00) begin
            tests_failed++; $display("FAIL sum_out_nm: got %0b want 00", nm);
        end
        tests_run++;
        if (wr_cnt !== 1 || wr_data !== 10'd21) begin
            tests_failed++;
            $display("FAIL sum_out_data: got %0d writes data %0d want 1 write data 21",
                     wr_cnt, wr_data);
        end
    endtask

    task automatic test_saturate();
        tok[0] = 10'd1000; tok[1] = 10'd1000; tok[2] = 10'd10; tok[3] = 10'd5; ptr = 0;
        fire(2'b00, 4'd4, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 6) begin
            tests_failed++; $display("FAIL sat_setup_done: got %0d want 6", done_cyc);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 5) begin
            tests_failed++; $display("FAIL sat_comp_done: got %0d want 5", done_cyc);
        end
        tests_run++;
        if (bus.data_out !== 10'd1023) begin
            tests_failed++; $display("FAIL sat_value: got %0d want 1023", bus.data_out);
        end
    endtask

    task automatic test_max_min_range();
        tok[0] = 10'd12; tok[1] = 10'd3; tok[2] = 10'd40; tok[3] = 10'd7; tok[4] = 10'd3;
        ptr = 0;
        fire(2'b00, 4'd5, 2'b01, 0);
        tests_run++;
        if (rd_cnt !== 5 || done_cyc !== 7) begin
            tests_failed++;
            $display("FAIL max_setup: got rd %0d done %0d want rd 5 done 7", rd_cnt, done_cyc);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (bus.data_out !== 10'd40 || done_cyc !== 6) begin
            tests_failed++;
            $display("FAIL max_value: got %0d done %0d want 40 done 6", bus.data_out, done_cyc);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (bus.data_out !== 10'd40) begin
            tests_failed++; $display("FAIL max_repeat: got %0d want 40", bus.data_out);
        end
        ptr = 0;
        fire(2'b00, 4'd5, 2'b10, 0);
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (bus.data_out !== 10'd3) begin
            tests_failed++; $display("FAIL min_value: got %0d want 3", bus.data_out);
        end
        ptr = 0;
        fire(2'b00, 4'd5, 2'b11, 0);
        fire(2'b01, 4'd0, 2'b00, 0);
        fire(2'b10, 4'd0, 2'b00, 0);
        tests_run++;
        if (wr_cnt !== 1 || wr_data !== 10'd37) begin
            tests_failed++;
            $display("FAIL range_value: got %0d writes data %0d want 1 write data 37",
                     wr_cnt, wr_data);
        end
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < 8; i++) tok[i] = 10'(i + 1);
        ptr = 0;
        fire(2'b00, 4'd0, 2'b00, 0);
        tests_run++;
        if (rd_cnt !== 8 || done_cyc !== 10) begin
            tests_failed++;
            $display("FAIL clamp0_setup: got rd %0d done %0d want rd 8 done 10", rd_cnt, done_cyc);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 9 || bus.data_out !== 10'd36) begin
            tests_failed++;
            $display("FAIL clamp0_comp: got done %0d data %0d want done 9 data 36",
                     done_cyc, bus.data_out);
        end
        for (int i = 0; i < 8; i++) tok[i] = 10'((i + 1) * 10);
        ptr = 0;
        fire(2'b00, 4'd11, 2'b00, 0);
        tests_run++;
        if (rd_cnt !== 8 || done_cyc !== 10) begin
            tests_failed++;
            $display("FAIL clamp11_setup: got rd %0d done %0d want rd 8 done 10", rd_cnt, done_cyc);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 9 || bus.data_out !== 10'd360) begin
            tests_failed++;
            $display("FAIL clamp11_comp: got done %0d data %0d want done 9 data 360",
                     done_cyc, bus.data_out);
        end
    endtask

    task automatic test_clear();
        tok[0] = 10'd5; tok[1] = 10'd7; tok[2] = 10'd9; ptr = 0;
        fire(2'b00, 4'd3, 2'b00, 0);
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (bus.data_out !== 10'd21) begin
            tests_failed++; $display("FAIL clear_pre: got %0d want 21", bus.data_out);
        end
        fire(2'b11, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 2 || nm !== 2'b00 || wr_cnt !== 0) begin
            tests_failed++;
            $display("FAIL clear_fire: got done %0d nm %0b wr %0d want done 2 nm 00 wr 0",
                     done_cyc, nm, wr_cnt);
        end
        tests_run++;
        if (bus.data_out !== 10'd0) begin
            tests_failed++; $display("FAIL clear_data: got %0d want 0", bus.data_out);
        end
        fire(2'b10, 4'd0, 2'b00, 0);
        tests_run++;
        if (wr_cnt !== 1 || wr_data !== 10'd0 || nm !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_out: got wr %0d data %0d nm %0b want wr 1 data 0 nm 00",
                     wr_cnt, wr_data, nm);
        end
        fire(2'b01, 4'd0, 2'b00, 0);
        tests_run++;
        if (bus.data_out !== 10'd21 || done_cyc !== 4) begin
            tests_failed++;
            $display("FAIL clear_recomp: got %0d done %0d want 21 done 4", bus.data_out, done_cyc);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        tok[0] = 10'd1; tok[1] = 10'd2; tok[2] = 10'd3; ptr = 0;
        @(negedge clk);
        bus.start_in = 1'b1; bus.next_mode_in = 2'b00; bus.length_in = 4'd3;
        bus.command_in = 2'b00;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 bus.data_in_fifo = tok[0];
        @(negedge clk);
        tests_run++;
        if (bus.rd_in_data_fifo !== 1'b1) begin
            tests_failed++; $display("FAIL abort_rd2: got %0b want 1", bus.rd_in_data_fifo);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.rd_in_data_fifo !== 1'b0 || bus.wr_out_fifo !== 1'b0 || bus.done_out !== 1'b0 ||
            bus.next_mode_out !== 2'b00 || bus.data_out !== 10'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got rd %0b wr %0b done %0b nm %0b data %0d want all 0",
                     bus.rd_in_data_fifo, bus.wr_out_fifo, bus.done_out, bus.next_mode_out,
                     bus.data_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done_out || bus.rd_in_data_fifo) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen_done);
        end
        fire(2'b10, 4'd0, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 2 || wr_data !== 10'd0) begin
            tests_failed++;
            $display("FAIL abort_idle: got done %0d data %0d want done 2 data 0",
                     done_cyc, wr_data);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        tok[0] = 10'd4; tok[1] = 10'd6; ptr = 0;
        fire(2'b00, 4'd2, 2'b00, 0);
        tests_run++;
        if (done_cyc !== 4) begin
            tests_failed++; $display("FAIL ign_setup_done: got %0d want 4", done_cyc);
        end
        for (int p = 2; p <= 3; p++) begin
            fire(2'b01, 4'd0, 2'b00, p);
            tests_run++;
            if (done_cyc !== 3 || nm !== 2'b10) begin
                tests_failed++;
                $display("FAIL ign_comp_p%0d: got done %0d nm %0b want done 3 nm 10",
                         p, done_cyc, nm);
            end
            extra = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (bus.done_out || bus.rd_in_data_fifo || bus.wr_out_fifo) extra++;
            end
            tests_run++;
            if (extra !== 0) begin
                tests_failed++;
                $display("FAIL ign_quiet_p%0d: got %0d active cycles want 0", p, extra);
            end
        end
        fire(2'b10, 4'd0, 2'b00, 0);
        tests_run++;
        if (wr_cnt !== 1 || wr_data !== 10'd10) begin
            tests_failed++;
            $display("FAIL ign_out: got wr %0d data %0d want wr 1 data 10", wr_cnt, wr_data);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        ptr              = 0;
        bus.start_in     = 1'b0;
        bus.next_mode_in = 2'b00;
        bus.length_in    = '0;
        bus.command_in   = 2'b00;
        bus.data_in_fifo = '0;
        test_reset();
        test_sum_basic();
        test_saturate();
        test_max_min_range();
        test_len_clamp();
        test_clear();
        test_reset_abort();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
